// File: rtl/axi_lite_aes_ctr_regs.sv
// AXI4-Lite register front end for an AES-CTR core.
// Exposes PT/ST/three key banks/KEY_SEL as writable registers, DONE/CT as
// read-only status, and a START register that launches the core.
// Ports:
//   s00_axi_aclk, s00_axi_areset   clock, synchronous active-high reset
//   s00_axi_aw*/w*/b*              AXI-Lite write address/data/response
//   s00_axi_ar*/r*                 AXI-Lite read address/data
//   core_start (pulse), core_pt, core_st, core_key   to the AES core
//   core_ct, core_done (pulse)                       from the AES core
module axi_lite_aes_ctr_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start,
    output logic [127:0]                      core_pt,
    output logic [127:0]                      core_st,
    output logic [191:0]                      core_key,
    input  logic [127:0]                      core_ct,
    input  logic                              core_done
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    // Index 0 of each multi-word field is the most-significant word.
    logic [31:0] pt   [0:3];
    logic [31:0] st   [0:3];
    logic [31:0] ct   [0:3];
    logic [31:0] key0 [0:5];
    logic [31:0] key1 [0:5];
    logic [31:0] key2 [0:5];
    logic        start_bit, done_bit, busy;
    logic [1:0]  key_sel;

    int unsigned wi, ri;
    logic        wr_ok, start_fire;
    logic [31:0] rd_word;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign wi = 32'(s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
    assign ri = 32'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);

    assign wr_ok = (wstate == W_ACK) && (wi <= 32'd32);
    // A completion arriving on the same edge is retired first, so it frees
    // the core for a START written in that very cycle.
    assign start_fire = wr_ok && (wi == 32'd0) && s00_axi_wstrb[0] &&
                        s00_axi_wdata[0] && !start_bit && !(busy && !core_done);

    // Write channel
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) wstate <= W_IDLE;
        else                wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt      = wstate;
        s00_axi_awready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        case (wstate)
            W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wstate_nxt = W_ACK;
            W_ACK: begin
                s00_axi_awready = 1'b1;
                s00_axi_wready  = 1'b1;
                wstate_nxt      = W_RESP;
            end
            W_RESP: begin
                s00_axi_bvalid = 1'b1;
                if (s00_axi_bready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset)       s00_axi_bresp <= 2'b00;
        else if (wstate == W_ACK) s00_axi_bresp <= (wi > 32'd32) ? 2'b10 : 2'b00;
    end

    // Register file and core handshake
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pt[i] <= '0;
                st[i] <= '0;
                ct[i] <= '0;
            end
            for (int unsigned i = 0; i < 6; i++) begin
                key0[i] <= '0;
                key1[i] <= '0;
                key2[i] <= '0;
            end
            start_bit  <= 1'b0;
            done_bit   <= 1'b0;
            busy       <= 1'b0;
            key_sel    <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= start_fire;
            if (core_done) begin
                for (int unsigned i = 0; i < 4; i++)
                    ct[i] <= core_ct[127 - 32*i -: 32];
                done_bit <= 1'b1;
                busy     <= 1'b0;
            end
            if (start_fire) begin
                busy     <= 1'b1;
                done_bit <= 1'b0;
            end
            if (wr_ok) begin
                if (wi == 32'd0) begin
                    if (s00_axi_wstrb[0]) start_bit <= s00_axi_wdata[0];
                end else if (wi <= 32'd4) begin
                    pt[2'(wi - 32'd1)] <= merge(pt[2'(wi - 32'd1)], s00_axi_wdata, s00_axi_wstrb);
                end else if (wi <= 32'd10) begin
                    key0[3'(wi - 32'd5)] <= merge(key0[3'(wi - 32'd5)], s00_axi_wdata, s00_axi_wstrb);
                end else if (wi >= 32'd16 && wi <= 32'd19) begin
                    st[2'(wi - 32'd16)] <= merge(st[2'(wi - 32'd16)], s00_axi_wdata, s00_axi_wstrb);
                end else if (wi >= 32'd20 && wi <= 32'd25) begin
                    key1[3'(wi - 32'd20)] <= merge(key1[3'(wi - 32'd20)], s00_axi_wdata, s00_axi_wstrb);
                end else if (wi >= 32'd26 && wi <= 32'd31) begin
                    key2[3'(wi - 32'd26)] <= merge(key2[3'(wi - 32'd26)], s00_axi_wdata, s00_axi_wstrb);
                end else if (wi == 32'd32) begin
                    if (s00_axi_wstrb[0]) key_sel <= s00_axi_wdata[1:0];
                end
                // DONE (11) and CT (12..15) are read-only: write is dropped.
            end
        end
    end

    // Read channel
    always_comb begin
        rd_word = '0;
        if (ri == 32'd0)                      rd_word = {31'b0, start_bit};
        else if (ri <= 32'd4)                 rd_word = pt[2'(ri - 32'd1)];
        else if (ri <= 32'd10)                rd_word = key0[3'(ri - 32'd5)];
        else if (ri == 32'd11)                rd_word = {31'b0, done_bit};
        else if (ri <= 32'd15)                rd_word = ct[2'(ri - 32'd12)];
        else if (ri <= 32'd19)                rd_word = st[2'(ri - 32'd16)];
        else if (ri <= 32'd25)                rd_word = key1[3'(ri - 32'd20)];
        else if (ri <= 32'd31)                rd_word = key2[3'(ri - 32'd26)];
        else if (ri == 32'd32)                rd_word = {30'b0, key_sel};
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) rstate <= R_IDLE;
        else                rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt      = rstate;
        s00_axi_arready = 1'b0;
        s00_axi_rvalid  = 1'b0;
        case (rstate)
            R_IDLE: if (s00_axi_arvalid) rstate_nxt = R_ACK;
            R_ACK: begin
                s00_axi_arready = 1'b1;
                rstate_nxt      = R_DATA;
            end
            R_DATA: begin
                s00_axi_rvalid = 1'b1;
                if (s00_axi_rready) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_rdata <= '0;
            s00_axi_rresp <= 2'b00;
        end else if (rstate == R_ACK) begin
            s00_axi_rdata <= (ri > 32'd32) ? 32'h0 : rd_word;
            s00_axi_rresp <= (ri > 32'd32) ? 2'b10 : 2'b00;
        end
    end

    // Core-facing fields
    assign core_pt = {pt[0], pt[1], pt[2], pt[3]};
    assign core_st = {st[0], st[1], st[2], st[3]};

    always_comb begin
        case (key_sel)
            2'd1:    core_key = {key1[0], key1[1], key1[2], key1[3], key1[4], key1[5]};
            2'd2:    core_key = {key2[0], key2[1], key2[2], key2[3], key2[4], key2[5]};
            default: core_key = {key0[0], key0[1], key0[2], key0[3], key0[4], key0[5]};
        endcase
    end

endmodule
